// File: rtl/vdp99_pkg.sv
// z80_vdp_99 shared definitions: register indices, write masks,
// status bit positions and VRAM address width.
package vdp99_pkg;

  localparam int ADDR_W = 14;

  localparam logic [2:0] REG_MODE0 = 3'd0;
  localparam logic [2:0] REG_MODE1 = 3'd1;
  localparam logic [2:0] REG_NAME  = 3'd2;
  localparam logic [2:0] REG_COLOR = 3'd3;
  localparam logic [2:0] REG_PGEN  = 3'd4;
  localparam logic [2:0] REG_SATTR = 3'd5;
  localparam logic [2:0] REG_SPGEN = 3'd6;
  localparam logic [2:0] REG_BDCOL = 3'd7;

  localparam int ST_F  = 7;
  localparam int ST_5S = 6;
  localparam int ST_C  = 5;

  function automatic logic [7:0] reg_mask(
    input logic [2:0] idx
  );
    case (idx)
      REG_MODE0: return 8'h03;
      REG_MODE1: return 8'hFF;
      REG_NAME:  return 8'h0F;
      REG_COLOR: return 8'hFF;
      REG_PGEN:  return 8'h07;
      REG_SATTR: return 8'h7F;
      REG_SPGEN: return 8'h07;
      REG_BDCOL: return 8'hFF;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/vdp99_strobe_edge.sv
// Rising-edge detector for the CPU I/O strobes.
// One history flop; rise is high while the strobe is first seen high.
module vdp99_strobe_edge (
  input  logic phi,
  input  logic reset,
  input  logic strb,
  output logic rise
);

  logic prev;

  always_ff @(posedge phi) begin
    if (!reset) prev <= 1'b0;
    else        prev <= strb;
  end

  assign rise = strb & ~prev;

endmodule

// File: rtl/z80_vdp_99.sv
// TMS9918-style CPU bus interface and register core.
// Optional macro Z80_VDP99_IRQ_EN enables the irq output.
module z80_vdp_99
  import vdp99_pkg::*;
(
  input  logic              phi,
  input  logic              reset,
  input  logic              cpu_mode,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  output logic              vram_re,
  input  logic [7:0]        vram_rdata,
  input  logic              frame_tick,
  input  logic              coinc_set,
  input  logic              fifth_set,
  input  logic [4:0]        fifth_num,
  output logic [7:0]        reg0,
  output logic [7:0]        reg1,
  output logic [7:0]        reg2,
  output logic [7:0]        reg3,
  output logic [7:0]        reg4,
  output logic [7:0]        reg5,
  output logic [7:0]        reg6,
  output logic [7:0]        reg7,
  output logic              irq
);

  logic              wr_rise, rd_rise;
  logic              wr_pend, rd_pend;
  logic              wr_mode, rd_mode;
  logic [7:0]        wr_data;
  logic [7:0]        regs [8];
  logic [ADDR_W-1:0] addr;
  logic [7:0]        lo, rbuf;
  logic              toggle, ra_wait;
  logic              st_f, st_5s, st_c;
  logic [4:0]        st_num;
  logic [7:0]        status;
  logic              busy, do_wr, do_rd, st_clr;

  vdp99_strobe_edge u_wr_edge (
    .phi   (phi),
    .reset (reset),
    .strb  (cpu_wr),
    .rise  (wr_rise)
  );

  vdp99_strobe_edge u_rd_edge (
    .phi   (phi),
    .reset (reset),
    .strb  (cpu_rd),
    .rise  (rd_rise)
  );

  // Accesses wait while a read-ahead is still in flight.
  assign busy   = vram_re | ra_wait;
  assign do_wr  = wr_pend & ~busy;
  assign do_rd  = rd_pend & ~busy & ~wr_pend;
  assign st_clr = do_rd & rd_mode;

  always_comb begin
    status        = '0;
    status[ST_F]  = st_f;
    status[ST_5S] = st_5s;
    status[ST_C]  = st_c;
    status[4:0]   = st_num;
  end

  always_ff @(posedge phi) begin
    if (!reset) begin
      wr_pend    <= 1'b0;
      rd_pend    <= 1'b0;
      wr_mode    <= 1'b0;
      rd_mode    <= 1'b0;
      wr_data    <= '0;
      addr       <= '0;
      lo         <= '0;
      rbuf       <= '0;
      toggle     <= 1'b0;
      ra_wait    <= 1'b0;
      st_f       <= 1'b0;
      st_5s      <= 1'b0;
      st_c       <= 1'b0;
      st_num     <= '0;
      cpu_dout   <= '0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      vram_we    <= 1'b0;
      vram_re    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      vram_we <= 1'b0;
      vram_re <= 1'b0;
      ra_wait <= vram_re;

      if (wr_rise) begin
        wr_pend <= 1'b1;
        wr_mode <= cpu_mode;
        wr_data <= cpu_din;
      end else if (do_wr) begin
        wr_pend <= 1'b0;
      end

      if (rd_rise) begin
        rd_pend <= 1'b1;
        rd_mode <= cpu_mode;
      end else if (do_rd) begin
        rd_pend <= 1'b0;
      end

      if (ra_wait) begin
        rbuf <= vram_rdata;
        addr <= addr + ADDR_W'(1);
      end

      if (do_wr) begin
        if (wr_mode) begin
          if (!toggle) begin
            lo     <= wr_data;
            toggle <= 1'b1;
          end else begin
            toggle <= 1'b0;
            if (wr_data[7]) begin
              regs[wr_data[2:0]] <= lo & reg_mask(wr_data[2:0]);
            end else begin
              addr <= {wr_data[5:0], lo};
              if (!wr_data[6]) begin
                vram_addr <= {wr_data[5:0], lo};
                vram_re   <= 1'b1;
              end
            end
          end
        end else begin
          vram_addr  <= addr;
          vram_wdata <= wr_data;
          vram_we    <= 1'b1;
          rbuf       <= wr_data;
          addr       <= addr + ADDR_W'(1);
          toggle     <= 1'b0;
        end
      end

      if (do_rd) begin
        toggle <= 1'b0;
        if (rd_mode) begin
          cpu_dout <= status;
        end else begin
          cpu_dout  <= rbuf;
          vram_addr <= addr;
          vram_re   <= 1'b1;
        end
      end

      // A set event in the same cycle as a status-read clear wins.
      st_f  <= frame_tick | (st_f & ~st_clr);
      st_c  <= coinc_set | (st_c & ~st_clr);
      st_5s <= fifth_set | (st_5s & ~st_clr);
      if (fifth_set && (!st_5s || st_clr)) st_num <= fifth_num;
    end
  end

  assign reg0 = regs[0];
  assign reg1 = regs[1];
  assign reg2 = regs[2];
  assign reg3 = regs[3];
  assign reg4 = regs[4];
  assign reg5 = regs[5];
  assign reg6 = regs[6];
  assign reg7 = regs[7];

`ifdef Z80_VDP99_IRQ_EN
  assign irq = st_f & regs[REG_MODE1][5];
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_z80_vdp_99.sv
// Directed self-checking bench for z80_vdp_99.
// Models VRAM as a 16K array with one-cycle read latency.
module tb_z80_vdp_99;

  logic        phi, reset;
  logic        cpu_mode, cpu_wr, cpu_rd;
  logic [7:0]  cpu_din, cpu_dout;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        vram_we, vram_re;
  logic        frame_tick, coinc_set, fifth_set;
  logic [4:0]  fifth_num;
  logic [7:0]  reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [7:0] mem [0:16383];
  logic [7:0] rd_val;
  logic       irq_on;
  int         we_base;

  z80_vdp_99 dut (
    .phi        (phi),
    .reset      (reset),
    .cpu_mode   (cpu_mode),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_re    (vram_re),
    .vram_rdata (vram_rdata),
    .frame_tick (frame_tick),
    .coinc_set  (coinc_set),
    .fifth_set  (fifth_set),
    .fifth_num  (fifth_num),
    .reg0       (reg0),
    .reg1       (reg1),
    .reg2       (reg2),
    .reg3       (reg3),
    .reg4       (reg4),
    .reg5       (reg5),
    .reg6       (reg6),
    .reg7       (reg7),
    .irq        (irq)
  );

  initial begin
    phi = 1'b0;
    forever #5 phi = ~phi;
  end

  always @(posedge phi) begin
    if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (vram_re) vram_rdata <= mem[vram_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic m, input logic [7:0] d);
    @(negedge phi);
    cpu_mode = m;
    cpu_din  = d;
    cpu_wr   = 1'b1;
    repeat (2) @(negedge phi);
    cpu_wr = 1'b0;
    repeat (4) @(negedge phi);
  endtask

  task automatic bus_rd(input logic m, output logic [7:0] d);
    @(negedge phi);
    cpu_mode = m;
    cpu_rd   = 1'b1;
    repeat (2) @(negedge phi);
    d      = cpu_dout;
    cpu_rd = 1'b0;
    repeat (4) @(negedge phi);
  endtask

  task automatic tick_pulse();
    @(negedge phi);
    frame_tick = 1'b1;
    @(negedge phi);
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef Z80_VDP99_IRQ_EN
    irq_on = 1'b1;
`else
    irq_on = 1'b0;
`endif
    reset      = 1'b0;
    cpu_mode   = 1'b0;
    cpu_din    = '0;
    cpu_wr     = 1'b0;
    cpu_rd     = 1'b0;
    frame_tick = 1'b0;
    coinc_set  = 1'b0;
    fifth_set  = 1'b0;
    fifth_num  = '0;
    repeat (3) @(negedge phi);
    check("rst_dout", cpu_dout, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_we", vram_we, 1'b0);
    check("rst_re", vram_re, 1'b0);
    check("rst_regs", {reg0, reg1, reg4, reg7}, 32'h0);
    reset = 1'b1;

    // reset between the two control bytes must clear toggle
    bus_wr(1'b1, 8'h55);
    @(negedge phi); reset = 1'b0;
    repeat (2) @(negedge phi); reset = 1'b1;
    bus_wr(1'b1, 8'hFF);
    bus_wr(1'b1, 8'h80);
    check("reg0_mask_after_rst", reg0, 8'h03);

    bus_wr(1'b1, 8'h70);
    bus_wr(1'b1, 8'h81);
    check("reg1", reg1, 8'h70);
    bus_wr(1'b1, 8'hFF);
    bus_wr(1'b1, 8'h84);
    check("reg4_mask", reg4, 8'h07);
    bus_wr(1'b1, 8'hFF);
    bus_wr(1'b1, 8'hFA);
    check("reg2_mask_ign_bits", reg2, 8'h0F);

    bus_wr(1'b1, 8'h00);
    bus_wr(1'b1, 8'h48);
    bus_wr(1'b0, 8'hAA);
    bus_wr(1'b0, 8'hBB);
    bus_wr(1'b0, 8'hCC);
    check("vram_800", mem[14'h0800], 8'hAA);
    check("vram_801", mem[14'h0801], 8'hBB);
    check("vram_802", mem[14'h0802], 8'hCC);

    bus_wr(1'b1, 8'h00);
    bus_wr(1'b1, 8'h48);
    bus_wr(1'b0, 8'h11);
    bus_wr(1'b0, 8'h22);
    bus_wr(1'b1, 8'h00);
    bus_wr(1'b1, 8'h08);
    bus_rd(1'b0, rd_val);
    check("rd_ahead_0", rd_val, 8'h11);
    bus_rd(1'b0, rd_val);
    check("rd_ahead_1", rd_val, 8'h22);
    repeat (3) @(negedge phi);
    check("dout_hold", cpu_dout, 8'h22);

    bus_wr(1'b1, 8'hFF);
    bus_wr(1'b1, 8'h7F);
    bus_wr(1'b0, 8'h5A);
    bus_wr(1'b0, 8'h5B);
    check("wrap_3fff", mem[14'h3FFF], 8'h5A);
    check("wrap_0000", mem[14'h0000], 8'h5B);

    bus_wr(1'b1, 8'h60);
    bus_wr(1'b1, 8'h81);
    check("irq_pre", irq, 1'b0);
    tick_pulse();
    check("irq_set", irq, irq_on);
    bus_rd(1'b1, rd_val);
    check("stat_f", rd_val, 8'h80);
    check("irq_clr", irq, 1'b0);
    bus_rd(1'b1, rd_val);
    check("stat_f_clr", rd_val, 8'h00);

    // frame_tick lands in the same cycle as the status clear
    tick_pulse();
    @(negedge phi);
    cpu_mode = 1'b1;
    cpu_rd   = 1'b1;
    @(negedge phi);
    frame_tick = 1'b1;
    @(negedge phi);
    frame_tick = 1'b0;
    rd_val = cpu_dout;
    cpu_rd = 1'b0;
    repeat (4) @(negedge phi);
    check("race_rd", rd_val, 8'h80);
    check("race_irq", irq, irq_on);
    bus_rd(1'b1, rd_val);
    check("race_f_kept", rd_val, 8'h80);
    bus_rd(1'b1, rd_val);
    check("race_f_gone", rd_val, 8'h00);

    @(negedge phi); fifth_set = 1'b1; fifth_num = 5'd5;
    @(negedge phi); fifth_num = 5'd9;
    @(negedge phi); fifth_set = 1'b0; coinc_set = 1'b1;
    @(negedge phi); coinc_set = 1'b0;
    bus_rd(1'b1, rd_val);
    check("stat_5s_c", rd_val, 8'h65);
    bus_rd(1'b1, rd_val);
    check("stat_num_kept", rd_val, 8'h05);

    bus_wr(1'b1, 8'h00);
    bus_wr(1'b1, 8'h41);
    we_base = we_cnt;
    @(negedge phi);
    cpu_mode = 1'b0;
    cpu_din  = 8'h77;
    cpu_wr   = 1'b1;
    repeat (4) @(negedge phi);
    cpu_wr = 1'b0;
    repeat (4) @(negedge phi);
    check("held_we_count", we_cnt - we_base, 1);
    bus_wr(1'b0, 8'h78);
    check("held_100", mem[14'h0100], 8'h77);
    check("held_101", mem[14'h0101], 8'h78);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
